tweak_rewind: RTL and testbench

TWEAK_REWIND -- requirements
Module: tweak_rewind

---
 rtl/tweak_rewind.sv | 138 +++++++++++++
 tb/tb_tweak_rewind.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweak_rewind.sv
// -----------------------------------------------------------------------------
// tweak_rewind
//
// Walks an XTS-style tweak backwards. Given the tweak T_n of block n, the
// block presents T_n, T_(n-1), ..., T_0 on a valid/ready stream. Each step
// multiplies by x^-1 in GF(2^128) mod x^128 + x^7 + x^2 + x + 1. This undoes
// the usual tweak doubler exactly.
//
// Handshake: a transfer happens on a rising edge where tweak_valid=1 and
// tweak_ready=1. While tweak_valid=1 and no transfer happens, tweak_out and
// idx_out stay stable. tweak_valid never depends combinationally on
// tweak_ready.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   n_rst        : asynchronous active-low reset
//   load         : start a sequence (accepted only in IDLE)
//   tweak_in     : tweak T_n, captured on an accepted load
//   idx_in       : block index n, captured with tweak_in
//   abort        : synchronous cancel; wins over load and over the handshake
//   tweak_ready  : consumer accepts tweak_out
//   tweak_out    : current tweak T_idx
//   idx_out      : block index of tweak_out
//   tweak_valid  : tweak_out / idx_out are valid (registered)
//   busy         : 1 in RUN and DONE (registered)
//   done         : one-cycle pulse after T_0 has been accepted (registered)
//   state_dbg    : current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module tweak_rewind #(
    parameter int TW_W  = 128,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [TW_W-1:0]  tweak_in,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             abort,
    input  logic             tweak_ready,
    output logic [TW_W-1:0]  tweak_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             tweak_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The doubler folds a carried-out bit 127 back in as 0x87. Undoing that
    // for an odd tweak means shifting right, then restoring bit 127 and
    // removing 0x87 >> 1 = 0x43 from the low bits.
    localparam logic [TW_W-1:0] HALVE_FIX =
        (TW_W'(1) << (TW_W - 1)) | TW_W'(8'h43);

    function automatic logic [TW_W-1:0] halve(input logic [TW_W-1:0] t);
        logic [TW_W-1:0] r;
        r = t >> 1;
        if (t[0]) begin
            r = r ^ HALVE_FIX;
        end
        return r;
    endfunction

    state_t            state;
    state_t            state_nx;
    logic [TW_W-1:0]   tweak_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic              handshake;

    assign handshake = tweak_valid & tweak_ready;
    assign state_dbg = state;

    // Next-state and datapath decisions.
    always_comb begin
        state_nx = state;
        tweak_nx = tweak_out;
        idx_nx   = idx_out;

        if (abort) begin
            // Data registers hold their last value; only control is cleared.
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state_nx = RUN;
                        tweak_nx = tweak_in;
                        idx_nx   = idx_in;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (idx_out == '0) begin
                            // T_0 consumed: finish, never wrap the index.
                            state_nx = DONE;
                        end else begin
                            tweak_nx = halve(tweak_out);
                            idx_nx   = idx_out - IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Loads arriving here are dropped, not queued.
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State, datapath and the registered status outputs. The status flags
    // are decoded from the next state so they line up with the state flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            tweak_out   <= '0;
            idx_out     <= '0;
            tweak_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            tweak_out   <= tweak_nx;
            idx_out     <= idx_nx;
            tweak_valid <= (state_nx == RUN);
            busy        <= (state_nx != IDLE);
            done        <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_tweak_rewind.sv
// -----------------------------------------------------------------------------
// tb_tweak_rewind
//
// Directed bench for tweak_rewind. Expected tweak chains are either
// hand-computed constants or built forward with an independent doubler model.
// chain[i] holds the tweak expected at block index i.
// -----------------------------------------------------------------------------
module tb_tweak_rewind;

    logic         tb_clk;
    logic         n_rst;
    logic         load;
    logic [127:0] tweak_in;
    logic [7:0]   idx_in;
    logic         abort;
    logic         tweak_ready;
    logic [127:0] tweak_out;
    logic [7:0]   idx_out;
    logic         tweak_valid;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    logic [127:0] chain [0:31];

    tweak_rewind #(.TW_W(128), .IDX_W(8)) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .load        (load),
        .tweak_in    (tweak_in),
        .idx_in      (idx_in),
        .abort       (abort),
        .tweak_ready (tweak_ready),
        .tweak_out   (tweak_out),
        .idx_out     (idx_out),
        .tweak_valid (tweak_valid),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // Forward doubler model.
    function automatic logic [127:0] dbl(input logic [127:0] t);
        logic [127:0] r;
        r = t << 1;
        if (t[127]) r = r ^ 128'h87;
        return r;
    endfunction

    // Expected chain for the idx 7 vector, low 16 bits hand-computed.
    task automatic fill_chain8();
        chain[7] = {{28{4'h5}}, 16'h7e2b};
        chain[6] = {{28{4'ha}}, 16'hbf56};
        chain[5] = {{28{4'h5}}, 16'h5fab};
        chain[4] = {{28{4'ha}}, 16'haf96};
        chain[3] = {{28{4'h5}}, 16'h57cb};
        chain[2] = {{28{4'ha}}, 16'haba6};
        chain[1] = {{28{4'h5}}, 16'h55d3};
        chain[0] = {32{4'ha}};
    endtask

    // Loads chain[n] with idx n and follows the stream down to index 0,
    // checking every presented value; rnd selects random backpressure.
    task automatic run_seq(input string name, input int n, input bit rnd);
        int   exp_idx;
        int   cycles;
        logic rdy;
        load        = 1'b1;
        tweak_in    = chain[n];
        idx_in      = n[7:0];
        tweak_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge tb_clk); #1;
        load    = 1'b0;
        exp_idx = n;
        cycles  = 0;
        while (exp_idx >= 0 && cycles < 2000) begin
            checks++;
            if (tweak_valid !== 1'b1 || idx_out !== exp_idx[7:0] ||
                tweak_out !== chain[exp_idx] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s step: valid=%b idx=%0d tweak=%h busy=%b done=%b, want valid=1 idx=%0d tweak=%h busy=1 done=0",
                         name, tweak_valid, idx_out, tweak_out, busy, done, exp_idx, chain[exp_idx]);
            end
            rdy = tweak_ready;
            @(posedge tb_clk); #1;
            if (rdy) exp_idx--;
            tweak_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycles++;
        end
        checks++;
        if (cycles >= 2000) begin
            errors++;
            $display("FAIL %s timeout: still at idx %0d after %0d cycles", name, exp_idx, cycles);
        end
        checks++;
        if (done !== 1'b1 || tweak_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b valid=%b busy=%b, want done=1 valid=0 busy=1",
                     name, done, tweak_valid, busy);
        end
        @(posedge tb_clk); #1;
        checks++;
        if (done !== 1'b0 || tweak_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: done=%b valid=%b busy=%b, want 0/0/0",
                     name, done, tweak_valid, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b1; load = 1'b0; abort = 1'b0; tweak_ready = 1'b0;
        tweak_in = '0; idx_in = '0;
        #1 n_rst = 1'b0;
        #2;  // before the first clock edge: reset must act asynchronously
        checks++;
        if (tweak_out !== 128'h0 || idx_out !== 8'h0 || tweak_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: tweak=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     tweak_out, idx_out, tweak_valid, busy, done);
        end
        repeat (2) @(posedge tb_clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic test_two_step();
        chain[1] = {{28{4'ha}}, 16'haba6};
        chain[0] = {{28{4'h5}}, 16'h55d3};
        run_seq("two_step", 1, 1'b0);
    endtask

    task automatic test_idx_zero();
        chain[0] = {{28{4'h5}}, 16'h55d3};
        run_seq("idx_zero", 0, 1'b0);
        chain[1] = {{28{4'h5}}, 16'h55d3};
        chain[0] = {32{4'ha}};
        run_seq("odd_step", 1, 1'b0);
    endtask

    task automatic test_chain8();
        fill_chain8();
        run_seq("chain8", 7, 1'b0);
        fill_chain8();
        run_seq("chain8_bp", 7, 1'b1);
    endtask

    task automatic test_random();
        int k;
        for (int l = 0; l < 20; l++) begin
            k = $urandom_range(0, 12);
            chain[0] = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 1; i <= k; i++) chain[i] = dbl(chain[i-1]);
            run_seq("random", k, 1'b1);
        end
    endtask

    task automatic test_load_ignored();
        chain[1] = {{28{4'ha}}, 16'haba6};
        chain[0] = {{28{4'h5}}, 16'h55d3};
        load = 1'b1; tweak_in = chain[1]; idx_in = 8'd1; tweak_ready = 1'b0;
        @(posedge tb_clk); #1;
        tweak_in = 128'hdead_beef; idx_in = 8'd9;  // load stays high
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tweak_valid !== 1'b1 || idx_out !== 8'd1 || tweak_out !== chain[1]) begin
                errors++;
                $display("FAIL load_in_run: valid=%b idx=%0d tweak=%h, want valid=1 idx=1 tweak=%h",
                         tweak_valid, idx_out, tweak_out, chain[1]);
            end
            @(posedge tb_clk); #1;
        end
        tweak_ready = 1'b1;
        @(posedge tb_clk); #1;
        checks++;
        if (tweak_valid !== 1'b1 || idx_out !== 8'd0 || tweak_out !== chain[0]) begin
            errors++;
            $display("FAIL load_ignored_step: valid=%b idx=%0d tweak=%h, want valid=1 idx=0 tweak=%h",
                     tweak_valid, idx_out, tweak_out, chain[0]);
        end
        @(posedge tb_clk); #1;
        checks++;
        if (done !== 1'b1 || tweak_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_ignored_done: done=%b valid=%b, want 1/0", done, tweak_valid);
        end
        @(posedge tb_clk); #1;  // load was high in the DONE cycle
        checks++;
        if (busy !== 1'b0 || tweak_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_in_done: busy=%b valid=%b done=%b, want 0/0/0", busy, tweak_valid, done);
        end
        load = 1'b0;
        @(posedge tb_clk); #1;
    endtask

    task automatic test_abort();
        fill_chain8();
        load = 1'b1; tweak_in = chain[7]; idx_in = 8'd7; tweak_ready = 1'b1;
        @(posedge tb_clk); #1;
        load = 1'b0;
        repeat (4) @(posedge tb_clk);
        #1;
        checks++;
        if (tweak_valid !== 1'b1 || idx_out !== 8'd3 || tweak_out !== chain[3]) begin
            errors++;
            $display("FAIL abort_pre: valid=%b idx=%0d tweak=%h, want valid=1 idx=3 tweak=%h",
                     tweak_valid, idx_out, tweak_out, chain[3]);
        end
        abort = 1'b1; load = 1'b1; tweak_in = 128'h1234; idx_in = 8'd5;
        @(posedge tb_clk); #1;
        abort = 1'b0; load = 1'b0;
        checks++;
        if (tweak_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            idx_out !== 8'd3 || tweak_out !== chain[3]) begin
            errors++;
            $display("FAIL abort: valid=%b busy=%b done=%b idx=%0d tweak=%h, want 0/0/0 idx=3 tweak=%h",
                     tweak_valid, busy, done, idx_out, tweak_out, chain[3]);
        end
        @(posedge tb_clk); #1;
        checks++;
        if (tweak_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: valid=%b busy=%b done=%b, want 0/0/0", tweak_valid, busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_chain8();
        load = 1'b1; tweak_in = chain[7]; idx_in = 8'd7; tweak_ready = 1'b1;
        @(posedge tb_clk); #1;
        load = 1'b0;
        repeat (2) @(posedge tb_clk);
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (tweak_out !== 128'h0 || idx_out !== 8'h0 || tweak_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: tweak=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
                     tweak_out, idx_out, tweak_valid, busy, done);
        end
        #1 n_rst = 1'b1;
        chain[1] = {{28{4'ha}}, 16'haba6};
        chain[0] = {{28{4'h5}}, 16'h55d3};
        run_seq("after_reset", 1, 1'b0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_two_step();
        test_idx_zero();
        test_chain8();
        test_load_ignored();
        test_random();
        test_abort();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
